// File: rtl/secded_pkg.sv
// Shared SECDED helpers: check-width derivation, codeword position mapping
// and the per-word classification.
package secded_pkg;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } class_e;

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Smallest R with 2^R >= data_w + R + 1 (data_w is limited to 4..64).
  function automatic int calc_r(input int data_w);
    int r;
    r = 0;
    for (int k = 1; k <= 8; k++) begin
      if (r == 0 && (1 << k) >= data_w + k + 1) r = k;
    end
    return r;
  endfunction

  function automatic int calc_chk_w(input int data_w);
    return calc_r(data_w) + 1;
  endfunction

  // Codeword position -> data bit index; -1 for check-bit positions.
  function automatic int pos_to_data_idx(input int pos);
    int n_pow;
    n_pow = 0;
    if (pos < 3 || is_pow2(pos)) return -1;
    for (int k = 0; k < 8; k++) begin
      if ((1 << k) <= pos) n_pow++;
    end
    return pos - n_pow - 1;
  endfunction

  // Data bit index -> codeword position (inverse of pos_to_data_idx).
  function automatic int data_to_pos(input int idx);
    int pos;
    pos = 0;
    for (int p = 3; p < 128; p++) begin
      if (pos == 0 && pos_to_data_idx(p) == idx) pos = p;
    end
    return pos;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of a received word.
module secded_syndrome
  import secded_pkg::*;
#(
  parameter int DATA_W = 16,
  localparam int R     = calc_r(DATA_W),
  localparam int CHK_W = R + 1
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [CHK_W-1:0]  chk_i,
  output logic [R-1:0]      syndrome_o,
  output logic              parity_o
);

  always_comb begin
    syndrome_o = '0;
    for (int d = 0; d < DATA_W; d++) begin
      if (data_i[d]) syndrome_o = syndrome_o ^ R'(data_to_pos(d));
    end
    for (int i = 0; i < R; i++) begin
      if (chk_i[i]) syndrome_o = syndrome_o ^ R'(1 << i);
    end
    parity_o = ^{data_i, chk_i};
  end

endmodule

// File: rtl/secded_pipe.sv
// Two-stage SECDED checker/corrector with valid/ready flow control and
// saturating error counters.
module secded_pipe
  import secded_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  localparam int R     = calc_r(DATA_W),
  localparam int CHK_W = R + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  input  logic              cfg_correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [R-1:0]      out_syndrome,
  output logic              out_sec,
  output logic              out_ded,
  output logic [CNT_W-1:0]  cnt_sec,
  output logic [CNT_W-1:0]  cnt_ded,
  input  logic              cnt_clr
);

  localparam int N = DATA_W + R;

  // Handshake: a word moves on a cycle where valid and ready are both high;
  // a stage loads whenever its successor is empty or is handing off.

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [R-1:0]      s1_syn_q,   s1_syn_d;
  logic              s1_par_q,   s1_par_d;
  logic              s1_corr_q,  s1_corr_d;

  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_data_q,  s2_data_d;
  logic [R-1:0]      s2_syn_q,   s2_syn_d;
  logic              s2_sec_q,   s2_sec_d;
  logic              s2_ded_q,   s2_ded_d;

  logic [CNT_W-1:0]  cnt_sec_q, cnt_sec_d;
  logic [CNT_W-1:0]  cnt_ded_q, cnt_ded_d;

  logic [R-1:0]      syn_w;
  logic              par_w;
  logic              s1_adv, s2_adv, out_fire;
  class_e            cls;
  logic [DATA_W-1:0] fixed_data;

  secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .data_i     (in_data),
    .chk_i      (in_chk),
    .syndrome_o (syn_w),
    .parity_o   (par_w)
  );

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = s2_valid_q && out_ready;

  // Classify the stage-1 word and flip the named data bit when allowed.
  always_comb begin
    cls = CLEAN;
    if (s1_par_q) begin
      cls = (int'(s1_syn_q) <= N) ? SEC : DED;
    end else if (s1_syn_q != '0) begin
      cls = DED;
    end
    fixed_data = s1_data_q;
    for (int d = 0; d < DATA_W; d++) begin
      if (cls == SEC && s1_corr_q && int'(s1_syn_q) == data_to_pos(d)) begin
        fixed_data[d] = ~s1_data_q[d];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_syn_d   = s1_syn_q;
    s1_par_d   = s1_par_q;
    s1_corr_d  = s1_corr_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_syn_d  = syn_w;
        s1_par_d  = par_w;
        s1_corr_d = cfg_correct_en;
      end
    end

    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_syn_d   = s2_syn_q;
    s2_sec_d   = s2_sec_q;
    s2_ded_d   = s2_ded_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = fixed_data;
        s2_syn_d  = s1_syn_q;
        s2_sec_d  = (cls == SEC);
        s2_ded_d  = (cls == DED);
      end
    end

    cnt_sec_d = cnt_sec_q;
    cnt_ded_d = cnt_ded_q;
    if (cnt_clr) begin
      cnt_sec_d = '0;
      cnt_ded_d = '0;
    end else if (out_fire) begin
      if (s2_sec_q && cnt_sec_q != '1) cnt_sec_d = cnt_sec_q + CNT_W'(1);
      if (s2_ded_q && cnt_ded_q != '1) cnt_ded_d = cnt_ded_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s1_par_q   <= 1'b0;
      s1_corr_q  <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_syn_q   <= '0;
      s2_sec_q   <= 1'b0;
      s2_ded_q   <= 1'b0;
      cnt_sec_q  <= '0;
      cnt_ded_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_syn_q   <= s1_syn_d;
      s1_par_q   <= s1_par_d;
      s1_corr_q  <= s1_corr_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_syn_q   <= s2_syn_d;
      s2_sec_q   <= s2_sec_d;
      s2_ded_q   <= s2_ded_d;
      cnt_sec_q  <= cnt_sec_d;
      cnt_ded_q  <= cnt_ded_d;
    end
  end

  assign out_valid    = s2_valid_q;
  assign out_data     = s2_data_q;
  assign out_syndrome = s2_syn_q;
  assign out_sec      = s2_sec_q;
  assign out_ded      = s2_ded_q;
  assign cnt_sec      = cnt_sec_q;
  assign cnt_ded      = cnt_ded_q;

endmodule

// File: tb/tb_secded_pipe.sv
// Bench for secded_pipe (DATA_W=16, CNT_W=2): vector table, random stream
// against a codeword-level model, stall, counter and reset sequences.
module tb_secded_pipe;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 2;
  localparam int R      = 5;
  localparam int CHK_W  = 6;
  localparam int N      = DATA_W + R;
  localparam int EXP_W  = DATA_W + R + 2;

  typedef logic [31:0] cw_t;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CHK_W-1:0]  c;
    logic              corr;
    logic [DATA_W-1:0] ed;
    logic [R-1:0]      es;
    logic              esec;
    logic              eded;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CHK_W-1:0] in_chk = '0;
  logic cfg_correct_en = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [R-1:0] out_syndrome;
  logic out_sec, out_ded;
  logic [CNT_W-1:0] cnt_sec, cnt_ded;
  logic cnt_clr = 1'b0;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [EXP_W-1:0] exp_q[$];
  int acc_q[$];
  logic [CNT_W-1:0] m_sec = '0;
  logic [CNT_W-1:0] m_ded = '0;
  bit chk_lat = 1'b0;
  bit hold_valid = 1'b0;
  logic [EXP_W-1:0] hold_val = '0;
  vec_t tbl[11];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  secded_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_chk         (in_chk),
    .cfg_correct_en (cfg_correct_en),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_syndrome   (out_syndrome),
    .out_sec        (out_sec),
    .out_ded        (out_ded),
    .cnt_sec        (cnt_sec),
    .cnt_ded        (cnt_ded),
    .cnt_clr        (cnt_clr)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- reference model (codeword level) ----------------
  function automatic bit pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // cw[0] is the overall parity bit, cw[1..N] the Hamming positions.
  function automatic cw_t to_cw(input logic [DATA_W-1:0] d, input logic [CHK_W-1:0] c);
    cw_t cw;
    int di;
    cw = '0;
    di = 0;
    cw[0] = c[CHK_W-1];
    for (int p = 1; p <= N; p++) begin
      if (pow2(p)) cw[p] = c[$clog2(p)];
      else begin
        cw[p] = d[di];
        di++;
      end
    end
    return cw;
  endfunction

  function automatic logic [DATA_W+CHK_W-1:0] from_cw(input cw_t cw);
    logic [DATA_W-1:0] d;
    logic [CHK_W-1:0] c;
    int di;
    d = '0;
    c = '0;
    di = 0;
    c[CHK_W-1] = cw[0];
    for (int p = 1; p <= N; p++) begin
      if (pow2(p)) c[$clog2(p)] = cw[p];
      else begin
        d[di] = cw[p];
        di++;
      end
    end
    return {d, c};
  endfunction

  function automatic logic [CHK_W-1:0] encode(input logic [DATA_W-1:0] d);
    cw_t cw;
    int syn;
    logic [CHK_W-1:0] c;
    cw = to_cw(d, '0);
    syn = 0;
    for (int p = 1; p <= N; p++) if (cw[p]) syn ^= p;
    c = {1'b0, R'(syn)};
    c[CHK_W-1] = ^{d, c[R-1:0]};
    return c;
  endfunction

  function automatic logic [EXP_W-1:0] model(input logic [DATA_W-1:0] d,
                                             input logic [CHK_W-1:0] c, input bit corr);
    cw_t cw;
    int syn, par;
    bit sec, ded;
    logic [DATA_W+CHK_W-1:0] dc;
    cw = to_cw(d, c);
    syn = 0;
    par = 0;
    sec = 1'b0;
    ded = 1'b0;
    for (int p = 0; p <= N; p++) begin
      if (cw[p]) begin
        syn ^= p;
        par ^= 1;
      end
    end
    if (par == 1) begin
      if (syn <= N) sec = 1'b1;
      else ded = 1'b1;
    end else if (syn != 0) begin
      ded = 1'b1;
    end
    if (sec && corr && syn > 2 && !pow2(syn)) cw[syn] = ~cw[syn];
    dc = from_cw(cw);
    return {dc[DATA_W+CHK_W-1:CHK_W], R'(syn), sec, ded};
  endfunction

  task automatic rand_word(output logic [DATA_W-1:0] d, output logic [CHK_W-1:0] c);
    cw_t cw;
    int k, a, b;
    d = DATA_W'($urandom);
    c = encode(d);
    k = $urandom_range(0, 3);
    if (k == 3) begin
      c = CHK_W'($urandom);
    end else if (k > 0) begin
      cw = to_cw(d, c);
      a = $urandom_range(0, N);
      cw[a] = ~cw[a];
      if (k == 2) begin
        b = $urandom_range(0, N - 1);
        if (b >= a) b++;
        cw[b] = ~cw[b];
      end
      {d, c} = from_cw(cw);
    end
  endtask

  // ---------------- driver + scoreboard, one clock per call ----------------
  task automatic run_cycle(input bit iv, input logic [DATA_W-1:0] d, input logic [CHK_W-1:0] c,
                           input bit corr, input bit ordy, input bit clr,
                           input logic [EXP_W-1:0] exp_in, output bit acc_o);
    logic [EXP_W-1:0] got, want;
    int acc;
    @(negedge clk);
    in_valid = iv;
    in_data = d;
    in_chk = c;
    cfg_correct_en = corr;
    out_ready = ordy;
    cnt_clr = clr;
    #1;
    got = {out_data, out_syndrome, out_sec, out_ded};
    check("cnt_sec", cnt_sec, m_sec);
    check("cnt_ded", cnt_ded, m_ded);
    if (hold_valid) begin
      check("stall_valid", out_valid, 1);
      check("stall_hold", got, hold_val);
    end
    hold_valid = out_valid && !out_ready;
    hold_val = got;
    acc_o = in_valid && in_ready;
    if (acc_o) begin
      exp_q.push_back(exp_in);
      acc_q.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out: got 0x%0h with no word outstanding (cycle %0d)", got, cyc);
      end else begin
        want = exp_q.pop_front();
        acc = acc_q.pop_front();
        check("out_word", got, want);
        if (chk_lat) check("latency", cyc - acc, 2);
        if (want[1] && m_sec != '1) m_sec++;
        if (want[0] && m_ded != '1) m_ded++;
      end
    end
    if (clr) begin
      m_sec = '0;
      m_ded = '0;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) run_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, a);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    cnt_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    acc_q.delete();
    m_sec = '0;
    m_ded = '0;
    hold_valid = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_word", {out_data, out_syndrome, out_sec, out_ded}, 0);
    check("rst_cnt_sec", cnt_sec, 0);
    check("rst_cnt_ded", cnt_ded, 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [DATA_W-1:0] d;
    logic [CHK_W-1:0] c;
    bit corr, iv, ordy, clr, a;
    int sent;

    tbl[0]  = '{16'h0000, 6'h00, 1'b1, 16'h0000, 5'd0,  1'b0, 1'b0};
    tbl[1]  = '{16'h0001, 6'h00, 1'b1, 16'h0000, 5'd3,  1'b1, 1'b0};
    tbl[2]  = '{16'h0001, 6'h00, 1'b0, 16'h0001, 5'd3,  1'b1, 1'b0};
    tbl[3]  = '{16'h0003, 6'h00, 1'b1, 16'h0003, 5'd6,  1'b0, 1'b1};
    tbl[4]  = '{16'h0000, 6'h20, 1'b1, 16'h0000, 5'd0,  1'b1, 1'b0};
    tbl[5]  = '{16'h0000, 6'h01, 1'b1, 16'h0000, 5'd1,  1'b1, 1'b0};
    tbl[6]  = '{16'h0001, 6'h23, 1'b1, 16'h0001, 5'd0,  1'b0, 1'b0};
    tbl[7]  = '{16'h0000, 6'h38, 1'b1, 16'h0000, 5'd24, 1'b0, 1'b1};
    tbl[8]  = '{16'h8000, 6'h00, 1'b1, 16'h0000, 5'd21, 1'b1, 1'b0};
    tbl[9]  = '{16'h8000, 6'h00, 1'b0, 16'h8000, 5'd21, 1'b1, 1'b0};
    tbl[10] = '{16'h8001, 6'h00, 1'b1, 16'h8001, 5'd22, 1'b0, 1'b1};

    do_reset();

    // Directed vectors, one word at a time, latency checked.
    chk_lat = 1'b1;
    for (int i = 0; i < 11; i++) begin
      run_cycle(1'b1, tbl[i].d, tbl[i].c, tbl[i].corr, 1'b1, 1'b0,
                {tbl[i].ed, tbl[i].es, tbl[i].esec, tbl[i].eded}, a);
      idle(3);
    end
    check("table_drain", exp_q.size(), 0);

    // Back-to-back stream: latency holds at full throughput.
    for (int i = 0; i < 10; i++) begin
      rand_word(d, c);
      run_cycle(1'b1, d, c, 1'b1, 1'b1, 1'b0, model(d, c, 1'b1), a);
      check("full_rate_accept", a, 1);
    end
    idle(4);
    chk_lat = 1'b0;

    // Eight words against an out_ready pattern of 1,0,0 repeating.
    sent = 0;
    for (int i = 0; i < 40; i++) begin
      rand_word(d, c);
      corr = $urandom_range(0, 1);
      run_cycle(sent < 8, d, c, corr, (i % 3) == 0, 1'b0, model(d, c, corr), a);
      if (a) sent++;
    end
    check("stall_sent", sent, 8);
    check("stall_drain", exp_q.size(), 0);

    // Counter saturation at CNT_W=2 and clear winning over an increment.
    do_reset();
    for (int i = 0; i < 5; i++)
      run_cycle(1'b1, 16'h0001, 6'h00, 1'b1, 1'b1, 1'b0, model(16'h0001, 6'h00, 1'b1), a);
    idle(3);
    check("cnt_sat", cnt_sec, 3);
    run_cycle(1'b1, 16'h0001, 6'h00, 1'b1, 1'b1, 1'b0, model(16'h0001, 6'h00, 1'b1), a);
    for (int i = 0; i < 6; i++) begin
      if (out_valid) begin
        run_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, '0, a);
        break;
      end
      run_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, a);
    end
    idle(1);
    check("cnt_clr_prec", cnt_sec, 0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      rand_word(d, c);
      corr = $urandom_range(0, 1);
      iv = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 6);
      clr = ($urandom_range(0, 49) == 0);
      run_cycle(iv, d, c, corr, ordy, clr, model(d, c, corr), a);
    end
    idle(20);
    check("random_drain", exp_q.size(), 0);

    // Reset with two words in flight.
    for (int i = 0; i < 2; i++) begin
      d = 16'h0001 << i;
      run_cycle(1'b1, d, 6'h00, 1'b1, 1'b0, 1'b0, model(d, 6'h00, 1'b1), a);
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, '0, a);
      check("post_reset_quiet", out_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/secded_pipe.md
SECDED_PIPE -- requirements
Module: secded_pipe

Interface
REQ-001 Parameter DATA_W, default 16: data word width; legal range 4..64.
REQ-002 Parameter CNT_W, default 16: width of each error counter.
REQ-003 Derived CHK_W = R+1, where R is the smallest integer with 2^R >= DATA_W+R+1; CHK_W = 6 for DATA_W = 16.
REQ-004 Port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 Port rst_n, input, 1: synchronous, active-low reset.
REQ-006 Port in_valid, input, 1: input word present.
REQ-007 Port in_ready, output, 1: block accepts the input word this cycle.
REQ-008 Port in_data, input, DATA_W: received data bits.
REQ-009 Port in_chk, input, CHK_W: [R-1:0] Hamming check bits; [CHK_W-1] overall parity bit.
REQ-010 Port cfg_correct_en, input, 1: 1 = correct single errors; 0 = detect and flag only.
REQ-011 Port out_valid, output, 1: result present.
REQ-012 Port out_ready, input, 1: consumer accepts the result.
REQ-013 Port out_data, output, DATA_W: corrected or passed-through data.
REQ-014 Port out_syndrome, output, R: Hamming syndrome of the word.
REQ-015 Port out_sec, output, 1: single error detected (corrected when enabled).
REQ-016 Port out_ded, output, 1: uncorrectable error.
REQ-017 Port cnt_sec, output, CNT_W: saturating count of delivered words with out_sec set.
REQ-018 Port cnt_ded, output, CNT_W: saturating count of delivered words with out_ded set.
REQ-019 Port cnt_clr, input, 1: clears both counters.

Function
REQ-020 Codeword layout: positions 1..DATA_W+R; position 2^i holds in_chk[i]; data bits fill the remaining positions in ascending order, in_data[0] first (position 3).
REQ-021 Syndrome = XOR of the position indices of all set bits; P = XOR of all DATA_W+CHK_W bits.
REQ-022 Classification: syndrome=0 and P=0 -> clean; P=1 and syndrome<=DATA_W+R -> SEC; P=0 and syndrome!=0 -> DED; P=1 and syndrome>DATA_W+R -> DED.
REQ-023 On SEC where the syndrome names a data position and cfg_correct_en=1, that data bit is inverted; in every other case out_data equals in_data.
REQ-024 cfg_correct_en is sampled with the word at input acceptance and travels with it.
REQ-025 Two-stage pipeline: stage 1 registers the word and its syndrome/P; stage 2 registers the corrected data and flags. Latency is 2 cycles from input handshake to out_valid with out_ready held high.
REQ-026 Throughput is one word per cycle when out_ready=1.
REQ-027 A stage advances when the downstream stage is empty or is transferring this cycle; in_ready = !s1_valid | !s2_valid | out_ready.
REQ-028 While out_valid=1 and out_ready=0, out_data, out_syndrome, out_sec and out_ded hold stable.
REQ-029 No word is dropped or duplicated under any in_valid/out_ready pattern.
REQ-030 A counter increments only on an output handshake (out_valid & out_ready) of a flagged word, and saturates at all-ones.
REQ-031 cnt_clr=1 sets both counters to 0 next cycle; cnt_clr takes precedence over a simultaneous increment.

Reset
REQ-032 With rst_n=0 at a clock edge: both stage valid bits, out_valid, out_sec, out_ded, cnt_sec and cnt_ded become 0; out_data and out_syndrome become 0.
REQ-033 Reset mid-stream discards every in-flight word; in_ready=1 in the first cycle after reset releases.

Structure
REQ-034 Package secded_pkg holds the CHK_W/R derivation function, the position-to-data-index mapping function and the classification enum {CLEAN, SEC, DED}.
REQ-035 Combinational syndrome and parity computation sits in one sub-module, secded_syndrome, instantiated in stage 1.

Verification (DATA_W=16, R=5)
REQ-036 in_data=0x0000, in_chk=0x00 -> out_data=0x0000, syndrome=0, sec=0, ded=0, at 2 cycles.
REQ-037 in_data=0x0001, in_chk=0x00, correct_en=1 -> out_data=0x0000, syndrome=3, sec=1; repeated with correct_en=0 -> out_data=0x0001, sec=1.
REQ-038 in_data=0x0003, in_chk=0x00 -> syndrome=6, ded=1, out_data=0x0003; in_chk=0x20 with data 0 -> sec=1, syndrome=0, data 0x0000.
REQ-039 Stream 8 words with out_ready toggling 1,0,0,1,... -> all 8 words emerge in order with no loss, and outputs stay stable while stalled.
REQ-040 CNT_W=2: deliver 5 SEC words -> cnt_sec=3; cnt_clr asserted on the same cycle as a 6th SEC delivery -> cnt_sec=0.
REQ-041 rst_n=0 with 2 words in flight -> no out_valid afterwards, and the counters read 0.
